// File: rtl/serial_frame_rx.sv
// Serial frame receiver. It samples a single-wire line on every rising edge.
// Frame format: start(1), WIDTH data bits LSB first, even parity, stop(0).
// A good stop bit delivers the word with a one-cycle valid pulse.
// A bad stop bit discards the word with a one-cycle frameErr pulse.
module serial_frame_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataBit,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parityErr,
  output logic             frameErr,
  output logic             busy,
  output logic [7:0]       frameCount
);

  // Sized so the index can hold WIDTH itself; it is incremented past the last bit.
  localparam int unsigned IdxW = $clog2(WIDTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state;
  logic [IdxW-1:0] index;
  logic [WIDTH-1:0] shiftReg;
  logic            rxParity;

  // Receiver FSM with registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      index      <= '0;
      shiftReg   <= '0;
      rxParity   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parityErr  <= 1'b0;
      frameErr   <= 1'b0;
      busy       <= 1'b0;
      frameCount <= '0;
    end else begin
      valid     <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (dataBit) begin
            state <= StData;
            index <= '0;
            busy  <= 1'b1;
          end
        end
        StData: begin
          // Decoded write keeps the select within the register's range.
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (index == IdxW'(i)) begin
              shiftReg[i] <= dataBit;
            end
          end
          index <= index + 1'b1;
          if (index == LastIdx) begin
            state <= StParity;
          end
        end
        StParity: begin
          rxParity <= dataBit;
          state    <= StStop;
        end
        StStop: begin
          // The stop sample never starts a new frame, even when it is 1.
          state <= StIdle;
          busy  <= 1'b0;
          if (!dataBit) begin
            data       <= shiftReg;
            valid      <= 1'b1;
            parityErr  <= rxParity ^ (^shiftReg);
            frameCount <= frameCount + 8'd1;
          end else begin
            frameErr <= 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with WIDTH = 8.
// The line is driven on negedge. Outputs are checked on negedge, after the sampling posedge.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset;
  logic       dataBit;
  logic [7:0] data;
  logic       valid;
  logic       parityErr;
  logic       frameErr;
  logic       busy;
  logic [7:0] frameCount;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;
  int firstValidCyc;

  serial_frame_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataBit   (dataBit),
    .data      (data),
    .valid     (valid),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .busy      (busy),
    .frameCount(frameCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive one line bit and advance to the next negedge.
  task automatic drive(input logic b);
    dataBit = b;
    @(negedge clk);
  endtask

  // Drives a full 11-bit frame. On return, the stop bit has just been sampled.
  task automatic sendFrame(input logic [7:0] w, input logic par, input logic stp);
    drive(1'b1);
    chk("busy_after_start", busy, 1);
    chk("valid_low_after_start", valid, 0);
    for (int i = 0; i < 8; i++) drive(w[i]);
    drive(par);
    chk("valid_not_early", valid, 0);
    chk("busy_before_stop", busy, 1);
    drive(stp);
  endtask

  initial begin
    reset   = 1'b1;
    dataBit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frameErr", frameErr, 0);
    chk("rst_parityErr", parityErr, 0);
    chk("rst_count", frameCount, 0);
    reset = 1'b0;

    // Idle line.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
      chk("idle_frameErr", frameErr, 0);
    end
    chk("idle_data", data, 0);
    chk("idle_count", frameCount, 0);

    // Good frame 0xA5 (four ones, so parity is 0).
    sendFrame(8'hA5, 1'b0, 1'b0);
    chk("a5_valid", valid, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_parityErr", parityErr, 0);
    chk("a5_frameErr", frameErr, 0);
    chk("a5_count", frameCount, 1);
    chk("a5_busy_fall", busy, 0);
    drive(1'b0);
    chk("a5_valid_drop", valid, 0);
    chk("a5_data_hold", data, 8'hA5);

    // Parity error: 0x01 needs parity 1, and 0 is sent.
    sendFrame(8'h01, 1'b0, 1'b0);
    chk("perr_valid", valid, 1);
    chk("perr_parityErr", parityErr, 1);
    chk("perr_data", data, 8'h01);
    chk("perr_count", frameCount, 2);
    drive(1'b0);
    chk("perr_parityErr_drop", parityErr, 0);
    chk("perr_valid_drop", valid, 0);

    // Framing error: 0x3C with correct parity 0 and a stop bit of 1.
    sendFrame(8'h3C, 1'b0, 1'b1);
    chk("ferr_frameErr", frameErr, 1);
    chk("ferr_valid", valid, 0);
    chk("ferr_data_hold", data, 8'h01);
    chk("ferr_count_hold", frameCount, 2);
    chk("ferr_busy_idle", busy, 0);
    drive(1'b0);
    chk("ferr_frameErr_drop", frameErr, 0);
    chk("ferr_no_restart", busy, 0);

    // Back-to-back: 0x01 (parity 1) then 0x80 (parity 1).
    sendFrame(8'h01, 1'b1, 1'b0);
    firstValidCyc = cyc;
    chk("b2b1_valid", valid, 1);
    chk("b2b1_data", data, 8'h01);
    chk("b2b1_parityErr", parityErr, 0);
    chk("b2b1_count", frameCount, 3);
    sendFrame(8'h80, 1'b1, 1'b0);
    chk("b2b2_valid", valid, 1);
    chk("b2b2_data", data, 8'h80);
    chk("b2b2_parityErr", parityErr, 0);
    chk("b2b2_count", frameCount, 4);
    chk("b2b_spacing", cyc - firstValidCyc, 11);
    drive(1'b0);
    chk("b2b_valid_drop", valid, 0);

    // Reset mid-frame: start and d0..d3 of 0xFF, then reset on the next edge.
    drive(1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1);
    reset = 1'b1;
    drive(1'b1);
    drive(1'b0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_count", frameCount, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      chk("post_rst_valid", valid, 0);
      chk("post_rst_frameErr", frameErr, 0);
      chk("post_rst_busy", busy, 0);
    end
    // 0x5A has four ones, so parity is 0.
    sendFrame(8'h5A, 1'b0, 1'b0);
    chk("5a_valid", valid, 1);
    chk("5a_data", data, 8'h5A);
    chk("5a_parityErr", parityErr, 0);
    chk("5a_count", frameCount, 1);
    drive(1'b0);
    chk("5a_valid_drop", valid, 0);
    chk("5a_count_hold", frameCount, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
